// File: rtl/prio_encoder_reg.sv
// Registered N-to-log2(N) priority encoder with valid/ready hold, fixed or round-robin selection.
// Define PRIO_ONEHOT_OUT_EN to add the registered one-hot grant_oh output.

module prio_encoder_reg #(
    parameter int N       = 8,
    parameter int W       = $clog2(N),
    parameter int RR_MODE = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] idx,
`ifdef PRIO_ONEHOT_OUT_EN
    output logic [N-1:0] grant_oh,
`endif
    output logic         any_req
);

    // state | meaning
    // IDLE  | no code held, out_valid=0, waiting for any request
    // HOLD  | idx held stable with out_valid=1 until out_ready accepts it
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] idx_q, idx_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic         any_req_q;
    logic         accept;

    // Round-robin: highest set bit at or below p wins; otherwise wrap to the highest set bit overall.
    // Fixed priority is the wrap-only case.
    function automatic logic [W-1:0] sel_fn(input logic [N-1:0] r, input logic [W-1:0] p);
        logic [W-1:0] s_all;
        logic [W-1:0] s_lo;
        logic         found_lo;
        s_all    = '0;
        s_lo     = '0;
        found_lo = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (r[i]) begin
                s_all = W'(i);
                if (W'(i) <= p) begin
                    s_lo     = W'(i);
                    found_lo = 1'b1;
                end
            end
        end
        if (RR_MODE != 0 && found_lo) begin
            return s_lo;
        end
        return s_all;
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        accept  = (state_q == HOLD) && out_ready;

        if (accept && (RR_MODE != 0)) begin
            ptr_d = (idx_q == '0) ? W'(N - 1) : idx_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (|req) begin
                    idx_d   = sel_fn(req, ptr_q);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (accept) begin
                    if (|req) begin
                        idx_d = sel_fn(req, ptr_d);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            ptr_q     <= W'(N - 1);
            any_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            any_req_q <= |req;
        end
    end

`ifdef PRIO_ONEHOT_OUT_EN
    logic [N-1:0] grant_oh_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_oh_q <= '0;
        end else if (state_d == HOLD) begin
            grant_oh_q <= {{(N-1){1'b0}}, 1'b1} << idx_d;
        end else begin
            grant_oh_q <= '0;
        end
    end

    assign grant_oh = grant_oh_q;
`endif

    assign out_valid = (state_q == HOLD);
    assign idx       = idx_q;
    assign any_req   = any_req_q;

endmodule

// File: tb/tb_prio_encoder_reg.sv
// Directed vector bench for prio_encoder_reg: one fixed-priority and one round-robin instance, N=8.
// Checks grant_oh as well when PRIO_ONEHOT_OUT_EN is defined.

module tb_prio_encoder_reg;

    logic       clk = 1'b0;
    logic       f_rst_n = 1'b0, r_rst_n = 1'b0;
    logic [7:0] f_req = '0, r_req = '0;
    logic       f_rdy = 1'b0, r_rdy = 1'b0;
    logic       f_valid, r_valid;
    logic [2:0] f_idx, r_idx;
    logic       f_any, r_any;
`ifdef PRIO_ONEHOT_OUT_EN
    logic [7:0] f_oh, r_oh;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    prio_encoder_reg #(.N(8), .RR_MODE(0)) u_fix (
        .clk(clk), .rst_n(f_rst_n), .req(f_req), .out_ready(f_rdy),
        .out_valid(f_valid), .idx(f_idx),
`ifdef PRIO_ONEHOT_OUT_EN
        .grant_oh(f_oh),
`endif
        .any_req(f_any)
    );

    prio_encoder_reg #(.N(8), .RR_MODE(1)) u_rr (
        .clk(clk), .rst_n(r_rst_n), .req(r_req), .out_ready(r_rdy),
        .out_valid(r_valid), .idx(r_idx),
`ifdef PRIO_ONEHOT_OUT_EN
        .grant_oh(r_oh),
`endif
        .any_req(r_any)
    );

    typedef struct {
        bit         rr;
        logic       rst_n;
        logic [7:0] req;
        logic       rdy;
        logic       ev;
        logic [2:0] ei;
        logic       ea;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit rr, logic rst_n, logic [7:0] req, logic rdy,
                                logic ev, logic [2:0] ei, logic ea);
        vec_t v;
        v.rr = rr; v.rst_n = rst_n; v.req = req; v.rdy = rdy;
        v.ev = ev; v.ei = ei; v.ea = ea;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int cnt[8];
    logic [7:0] exp_oh;

    initial begin
        // Fixed mode: reset, load idx=2, hold through a req change, release.
        add(0, 0, 8'h00, 0, 0, 0, 0);
        add(0, 0, 8'h00, 0, 0, 0, 0);
        add(0, 1, 8'h06, 0, 1, 2, 1);
        for (int k = 0; k < 5; k++) add(0, 1, 8'h80, 0, 1, 2, 1);
        add(0, 1, 8'h00, 1, 0, 2, 0);
        // Fixed mode: reset, idle 10 cycles (out_ready ignored), all bits, back-to-back bit 0, drain.
        add(0, 0, 8'h00, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) add(0, 1, 8'h00, logic'(k % 2), 0, 0, 0);
        add(0, 1, 8'hFF, 0, 1, 7, 1);
        add(0, 1, 8'h01, 1, 1, 0, 1);
        add(0, 1, 8'h00, 1, 0, 0, 0);
        // RR: all lines requesting -> 7..0 then 7, no bubble.
        add(1, 0, 8'h00, 0, 0, 0, 0);
        for (int k = 0; k < 9; k++) add(1, 1, 8'hFF, 1, 1, 3'(7 - (k % 8)), 1);
        // RR: two lines alternate, then wrap from 0 to 7.
        add(1, 0, 8'h00, 0, 0, 0, 0);
        add(1, 1, 8'h24, 1, 1, 5, 1);
        add(1, 1, 8'h24, 1, 1, 2, 1);
        add(1, 1, 8'h24, 1, 1, 5, 1);
        add(1, 1, 8'h24, 1, 1, 2, 1);
        add(1, 1, 8'h81, 1, 1, 0, 1);
        add(1, 1, 8'h81, 1, 1, 7, 1);
        add(1, 1, 8'h00, 1, 0, 7, 0);
        // RR: reach idx=5 with ptr=4, reset mid-hold, pointer must be back at 7.
        add(1, 0, 8'h00, 0, 0, 0, 0);
        add(1, 1, 8'hFF, 1, 1, 7, 1);
        add(1, 1, 8'hFF, 1, 1, 6, 1);
        add(1, 1, 8'hFF, 1, 1, 5, 1);
        add(1, 1, 8'h20, 1, 1, 5, 1);
        add(1, 1, 8'h20, 0, 1, 5, 1);
        add(1, 0, 8'hFF, 0, 0, 0, 0);
        add(1, 1, 8'hFF, 0, 1, 7, 1);
        add(1, 1, 8'hFF, 0, 1, 7, 1);
        add(1, 1, 8'hFF, 1, 1, 6, 1);

        foreach (vecs[n]) begin
            if (vecs[n].rr) begin
                r_rst_n = vecs[n].rst_n; r_req = vecs[n].req; r_rdy = vecs[n].rdy;
            end else begin
                f_rst_n = vecs[n].rst_n; f_req = vecs[n].req; f_rdy = vecs[n].rdy;
            end
            tick();
            exp_oh = vecs[n].ev ? (8'h01 << vecs[n].ei) : 8'h00;
            if (vecs[n].rr) begin
                chk($sformatf("v%0d rr out_valid", n), 32'(r_valid), 32'(vecs[n].ev));
                chk($sformatf("v%0d rr idx", n), 32'(r_idx), 32'(vecs[n].ei));
                chk($sformatf("v%0d rr any_req", n), 32'(r_any), 32'(vecs[n].ea));
`ifdef PRIO_ONEHOT_OUT_EN
                chk($sformatf("v%0d rr grant_oh", n), 32'(r_oh), 32'(exp_oh));
`endif
            end else begin
                chk($sformatf("v%0d fix out_valid", n), 32'(f_valid), 32'(vecs[n].ev));
                chk($sformatf("v%0d fix idx", n), 32'(f_idx), 32'(vecs[n].ei));
                chk($sformatf("v%0d fix any_req", n), 32'(f_any), 32'(vecs[n].ea));
`ifdef PRIO_ONEHOT_OUT_EN
                chk($sformatf("v%0d fix grant_oh", n), 32'(f_oh), 32'(exp_oh));
`endif
            end
        end

        // RR fairness: 16 consecutive accepts with all lines up -> each index exactly twice.
        r_rst_n = 1'b0; r_req = 8'h00; r_rdy = 1'b0;
        tick();
        r_rst_n = 1'b1; r_req = 8'hFF; r_rdy = 1'b1;
        for (int i = 0; i < 8; i++) cnt[i] = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            chk($sformatf("fair%0d valid", k), 32'(r_valid), 32'd1);
            chk($sformatf("fair%0d order", k), 32'(r_idx), 32'(7 - (k % 8)));
            if (r_valid) cnt[r_idx]++;
        end
        for (int i = 0; i < 8; i++) chk($sformatf("fair count idx%0d", i), 32'(cnt[i]), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
